// File: rtl/keccak_in_packer_if.sv
// Word-in / block-out handshake bundle for keccak_in_packer.
// slave is the packer's view, master is the feeding/consuming environment's view.
interface keccak_in_packer_if #(
    parameter int unsigned WORDS = 16
);
    localparam int unsigned BW = $clog2(4 * WORDS + 1);

    logic [31:0]          in32;
    logic                 in_valid;
    logic                 in_last;
    logic [1:0]           in_byte_num;
    logic                 in_accept;

    logic [32*WORDS-1:0]  out512;
    logic                 out_valid;
    logic                 out_last;
    logic [BW-1:0]        out_bytes;
    logic                 out_ready;

    modport slave (
        input  in32, in_valid, in_last, in_byte_num, out_ready,
        output in_accept, out512, out_valid, out_last, out_bytes
    );

    modport master (
        output in32, in_valid, in_last, in_byte_num, out_ready,
        input  in_accept, out512, out_valid, out_last, out_bytes
    );
endinterface

// File: rtl/keccak_in_packer.sv
// Packs a 32-bit word stream into WORDS-word blocks for keccak_ctrl, tagging the final block.
// Optional block counter output blk_cnt is enabled by defining KECCAK_PACK_BLKCNT_EN.
module keccak_in_packer #(
    parameter int unsigned WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
`ifdef KECCAK_PACK_BLKCNT_EN
    keccak_in_packer_if.slave bus,
    output logic [15:0]       blk_cnt
`else
    keccak_in_packer_if.slave bus
`endif
);
    localparam int unsigned DW = 32 * WORDS;
    localparam int unsigned CW = $clog2(WORDS + 1);
    localparam int unsigned BW = $clog2(4 * WORDS + 1);
    localparam int unsigned AW = $clog2(DW);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [DW-1:0]  data_q;
    logic           last_q;
    logic [BW-1:0]  bytes_q;

    logic           accept;
    logic           valid;
    logic           take;
    logic           handoff;
    logic           blk_full;
    logic [31:0]    last_word;
    logic [AW-1:0]  slot_lsb;

    assign take     = bus.in_valid & accept;
    assign handoff  = valid & bus.out_ready;
    assign blk_full = (cnt_q == CW'(WORDS - 1));

    // Word k sits at the top of the block, so slot 0 starts at bit DW-32.
    assign slot_lsb = AW'((WORDS - 1 - 32'(cnt_q)) * 32);

    always_comb begin
        last_word = bus.in32;
        case (bus.in_byte_num)
            2'd1:    last_word[23:0] = '0;
            2'd2:    last_word[15:0] = '0;
            2'd3:    last_word[7:0]  = '0;
            default: last_word       = bus.in32;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        valid   = 1'b0;
        case (state_q)
            FILL: begin
                accept = 1'b1;
                if (bus.in_valid && (bus.in_last || blk_full)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = last_q ? DONE : FILL;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            bytes_q <= '0;
        end else if (take) begin
            if (bus.in_last) begin
                if (bus.in_byte_num != 2'd0) begin
                    data_q[slot_lsb +: 32] <= last_word;
                end
                // 4*cnt leaves the two low bits free for the partial byte count.
                bytes_q <= BW'({cnt_q, 2'b00}) | BW'(bus.in_byte_num);
                last_q  <= 1'b1;
            end else begin
                data_q[slot_lsb +: 32] <= bus.in32;
                cnt_q                  <= cnt_q + CW'(1);
                if (blk_full) begin
                    bytes_q <= BW'(4 * WORDS);
                    last_q  <= 1'b0;
                end
            end
        end else if (handoff) begin
            data_q <= '0;
            cnt_q  <= '0;
        end
    end

    assign bus.in_accept = accept;
    assign bus.out_valid = valid;
    assign bus.out512    = data_q;
    assign bus.out_last  = last_q;
    assign bus.out_bytes = bytes_q;

`ifdef KECCAK_PACK_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_cnt_q <= '0;
        end else if (handoff && (blk_cnt_q != '1)) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule
